// File: rtl/oldland_cpuid_pkg.sv
// Shared definitions for the CPUID dump streamer: state encoding and sizing.
package oldland_cpuid_pkg;

  localparam int CPUID_NUM_REGS = 6;
  localparam int CPUID_SEL_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_EMIT = 3'd2,
    ST_CSUM = 3'd3,
    ST_FIN  = 3'd4
  } cpuid_state_t;

endpackage

// File: rtl/oldland_cpuid_dump.sv
// Streams NUM_REGS CPUID words out of a ready/valid port, followed by their
// XOR checksum tagged with out_last, then pulses done for one cycle.
// The CPUID block itself lives beside this module; it is only addressed
// through reg_sel and answers combinationally on val.
module oldland_cpuid_dump
  import oldland_cpuid_pkg::*;
#(
  parameter int NUM_REGS = CPUID_NUM_REGS  // legal range 1..8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic [CPUID_SEL_W-1:0] reg_sel,
  input  logic [31:0]            val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic                   done
);

  localparam logic [CPUID_SEL_W-1:0] LAST_IDX = CPUID_SEL_W'(NUM_REGS - 1);

  cpuid_state_t           state, state_n;
  logic [CPUID_SEL_W-1:0] idx, idx_n;
  logic [31:0]            csum, csum_n;
  logic [31:0]            data_n;
  logic                   valid_n, last_n;

  // State and stream registers; reset drops any pending word on the floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      csum      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      csum      <= csum_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_last  <= last_n;
    end
  end

  // Next-state and datapath updates; everything holds unless a step fires.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    csum_n  = csum;
    data_n  = out_data;
    valid_n = out_valid;
    last_n  = out_last;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SEL;
          idx_n   = '0;
          csum_n  = '0;
        end
      end
      ST_SEL: begin
        // val is combinational from the CPUID block for reg_sel == idx.
        data_n  = val;
        csum_n  = csum ^ val;
        valid_n = 1'b1;
        state_n = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_valid && out_ready) begin
          if (idx == LAST_IDX) begin
            // Checksum follows the last word back-to-back, valid stays up.
            data_n  = csum;
            last_n  = 1'b1;
            state_n = ST_CSUM;
          end else begin
            idx_n   = idx + 1'b1;
            valid_n = 1'b0;
            state_n = ST_SEL;
          end
        end
      end
      ST_CSUM: begin
        if (out_valid && out_ready) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          state_n = ST_FIN;
        end
      end
      ST_FIN: begin
        // Park idx at 0 so reg_sel reads 0 throughout IDLE.
        idx_n   = '0;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        valid_n = 1'b0;
        last_n  = 1'b0;
      end
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_FIN);
  assign reg_sel = idx;

endmodule
